// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: sync counters, host write port, RAM port and line-buffer port of the arbiter
interface vga_fb_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 16,
  parameter int LBW = 6
);
  logic [12:0] locX;
  logic [12:0] locY;
  logic host_valid;
  logic host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic ram_en;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic lb_we;
  logic [LBW-1:0] lb_addr;
  logic lb_bank;
  logic [DW-1:0] lb_wdata;
  logic fetch_busy;
  logic late_err;
  modport master (
    input locX, locY, host_valid, host_addr, host_data, ram_rdata,
    output host_ready, ram_en, ram_we, ram_addr, ram_wdata, lb_we, lb_addr, lb_bank, lb_wdata,
      fetch_busy, late_err
  );
  modport slave (
    output locX, locY, host_valid, host_addr, host_data, ram_rdata,
    input host_ready, ram_en, ram_we, ram_addr, ram_wdata, lb_we, lb_addr, lb_bank, lb_wdata,
      fetch_busy, late_err
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer RAM between the blanking-time line prefetch and host writes
module vga_fb_arbiter #(
  parameter int RES_V = 480,
  parameter int MAX_V = 524,
  parameter int FETCH_X = 648,
  parameter int WORDS_PER_LINE = 40,
  parameter int AW = 15,
  parameter int DW = 16,
  parameter int LBW = 6,
  parameter int RD_LAT = 2
) (
  input logic PIXEL_CLK,
  input logic RESET,
  vga_fb_arbiter_if.master bus
);
  localparam int CNW = LBW + 1;
  localparam int DCW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;
  logic synced;
  logic bank;
  logic [AW-1:0] base;
  logic [AW-1:0] next_base;
  logic [CNW-1:0] cnt;
  logic [LBW-1:0] rd_idx;
  logic [DCW-1:0] dcnt;
  logic [RD_LAT-1:0] pv;
  logic [LBW-1:0] pi [RD_LAT];
  logic [12:0] tgt;
  logic [AW-1:0] start_base;
  logic hit;
  logic trig;
  // trigger decode, host handshake and line-buffer outputs taken from the delay pipe
  always_comb begin
    tgt = bus.locY == 13'(MAX_V) ? '0 : bus.locY + 13'd1;
    hit = bus.locX == 13'(FETCH_X);
    trig = hit && tgt < 13'(RES_V) && (synced || tgt == '0);
    start_base = tgt == '0 ? '0 : next_base;
    bus.host_ready = !RESET && state == IDLE && !trig;
    bus.fetch_busy = state != IDLE;
    bus.lb_we = pv[RD_LAT-1];
    bus.lb_addr = pi[RD_LAT-1];
    bus.lb_bank = bank;
    bus.lb_wdata = bus.ram_rdata;
  end
  // fetch FSM with registered RAM port; reads are tagged and delayed RD_LAT cycles to the line buffer
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      state <= IDLE;
      synced <= 1'b0;
      bank <= 1'b0;
      base <= '0;
      next_base <= '0;
      cnt <= '0;
      rd_idx <= '0;
      dcnt <= '0;
      pv <= '0;
      for (int k = 0; k < RD_LAT; k++) pi[k] <= '0;
      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
      bus.late_err <= 1'b0;
    end else begin
      if (hit && tgt == '0) synced <= 1'b1;
      if (trig && state != IDLE) bus.late_err <= 1'b1;
      pv[0] <= bus.ram_en && !bus.ram_we;
      pi[0] <= rd_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        pi[k] <= pi[k-1];
      end
      case (state)
        IDLE: begin
          if (trig) begin
            state <= FETCH;
            base <= start_base;
            bank <= tgt[0];
            cnt <= CNW'(1);
            rd_idx <= '0;
            bus.ram_en <= 1'b1;
            bus.ram_we <= 1'b0;
            bus.ram_addr <= start_base;
          end else if (bus.host_valid) begin
            bus.ram_en <= 1'b1;
            bus.ram_we <= 1'b1;
            bus.ram_addr <= bus.host_addr;
            bus.ram_wdata <= DW'(bus.host_data);
          end else begin
            bus.ram_en <= 1'b0;
            bus.ram_we <= 1'b0;
          end
        end
        FETCH: begin
          if (cnt == CNW'(WORDS_PER_LINE)) begin
            state <= DRAIN;
            dcnt <= '0;
            next_base <= base + AW'(WORDS_PER_LINE);
            bus.ram_en <= 1'b0;
          end else begin
            cnt <= cnt + CNW'(1);
            rd_idx <= cnt[LBW-1:0];
            bus.ram_addr <= bus.ram_addr + AW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DCW'(RD_LAT - 1)) state <= IDLE;
          else dcnt <= dcnt + DCW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
